// File: rtl/pim_issue_ctrl.sv
// Issue controller for custom PIM-opcode instructions: forms rs1+imm, handshakes the
// request to the PIM macro, stalls EX until response/timeout, and drives writeback.
module pim_issue_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pim_valid,
    input  logic              i_flush,
    input  logic [2:0]        i_funct3,
    input  logic [DATA_W-1:0] i_rs1_data,
    input  logic [DATA_W-1:0] i_rs2_data,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [4:0]        i_rd,
    output logic              o_stall,
    output logic              o_pim_req_valid,
    input  logic              i_pim_req_ready,
    output logic [DATA_W-1:0] o_pim_addr,
    output logic [DATA_W-1:0] o_pim_wdata,
    output logic [2:0]        o_pim_op,
    input  logic              i_pim_resp_valid,
    input  logic [DATA_W-1:0] i_pim_resp_data,
    input  logic              i_pim_resp_err,
    output logic              o_wb_en,
    output logic [4:0]        o_wb_rd,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_err
);

    // state | meaning
    // IDLE  | waiting for a PIM instruction in EX
    // REQ   | request presented, waiting for macro ready
    // WAIT  | request accepted, waiting for response or timeout
    // DONE  | one-cycle writeback / error report, stall released

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic        kill;
    logic        wr_q;
    logic [4:0]  rd_q;

    logic              kill_nxt;
    logic              fin_err;
    logic              fin_wb;
    logic [DATA_W-1:0] fin_data;

    // Completion terms: a missing response (timeout) is reported as an error.
    always_comb begin
        kill_nxt = kill | i_flush;
        fin_err  = i_pim_resp_valid ? i_pim_resp_err : 1'b1;
        fin_wb   = wr_q & ~fin_err & ~kill_nxt & (rd_q != 5'd0);
        fin_data = fin_wb ? i_pim_resp_data : '0;
    end

    assign o_stall = (state == S_REQ) || (state == S_WAIT) ||
                     ((state == S_IDLE) && i_pim_valid && !i_flush);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= S_IDLE;
            cnt             <= '0;
            kill            <= 1'b0;
            wr_q            <= 1'b0;
            rd_q            <= '0;
            o_pim_req_valid <= 1'b0;
            o_pim_addr      <= '0;
            o_pim_wdata     <= '0;
            o_pim_op        <= '0;
            o_wb_en         <= 1'b0;
            o_wb_rd         <= '0;
            o_wb_data       <= '0;
            o_err           <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_pim_valid && !i_flush) begin
                        o_pim_addr      <= i_rs1_data + i_imm;
                        o_pim_wdata     <= i_rs2_data;
                        o_pim_op        <= i_funct3;
                        rd_q            <= i_rd;
                        wr_q            <= i_funct3[2];
                        o_pim_req_valid <= 1'b1;
                        state           <= S_REQ;
                    end
                end
                S_REQ: begin
                    // An accepted handshake cannot be recalled, so it wins over flush.
                    if (i_pim_req_ready) begin
                        o_pim_req_valid <= 1'b0;
                        cnt             <= '0;
                        kill            <= i_flush;
                        state           <= S_WAIT;
                    end else if (i_flush) begin
                        o_pim_req_valid <= 1'b0;
                        state           <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    kill <= kill_nxt;
                    if (i_pim_resp_valid || (cnt == CNT_LAST)) begin
                        o_wb_en   <= fin_wb;
                        o_wb_rd   <= fin_wb ? rd_q : 5'd0;
                        o_wb_data <= fin_data;
                        o_err     <= fin_err & ~kill_nxt;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    o_wb_en   <= 1'b0;
                    o_wb_rd   <= '0;
                    o_wb_data <= '0;
                    o_err     <= 1'b0;
                    kill      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
